systolic_drain: RTL

- Output-side reader for the N×N FP-INT systolic MAC array.
- On the array's done rising edge, snapshots every PE's accumulator (acc_out) and block exponent (exp_out).
- Converts each snapshot to IEEE FP16 and streams the results out row-major over a valid/ready interface, one element per cycle when not back-pressured.
- Sits between the systolic array and the activation writeback / next-layer feeder.

---
 rtl/systolic_drain.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/systolic_drain.sv
// Drains the N x N MAC array: on a done rising edge it snapshots every PE accumulator and exponent,
// then streams the results as FP16 in row-major order over a valid/ready handshake.
module systolic_drain #(
    parameter int ACC_WIDTH = 32,
    parameter int N         = 2,
    parameter int FRAC_BITS = 10,
    localparam int NPE      = N * N,
    localparam int IDX_W    = (NPE > 1) ? $clog2(NPE) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     done_in,
    input  logic [NPE*ACC_WIDTH-1:0] acc_in,
    input  logic [NPE*5-1:0]         exp_in,
    output logic [15:0]              res_data,
    output logic [IDX_W-1:0]         res_idx,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic                     res_last,
    output logic                     busy,
    output logic                     overrun
);

    typedef enum logic [1:0] {IDLE, LOAD, SEND} state_t;

    state_t                 state_q, state_d;
    logic                   done_q;
    logic [ACC_WIDTH-1:0]   snap_acc_q [NPE];
    logic [4:0]             snap_exp_q [NPE];
    logic [IDX_W-1:0]       idx_q, idx_d, nxt_idx;
    logic [15:0]            data_q, data_d;
    logic                   valid_q, valid_d;
    logic                   last_q, last_d;
    logic                   busy_q, busy_d;
    logic                   ovr_q, ovr_d;
    logic                   done_edge;
    logic                   capture;

    // Value = signed(acc) * 2^(exp - 15 - FRAC_BITS), truncated, flushed to zero below the normal range.
    function automatic logic [15:0] fp16_convert(input logic [ACC_WIDTH-1:0] acc,
                                                 input logic [4:0] ex);
        logic                 s;
        logic [ACC_WIDTH-1:0] m;
        logic [ACC_WIDTH-1:0] norm;
        logic [9:0]           mant;
        logic [15:0]          res;
        int                   p;
        int                   e;
        s = acc[ACC_WIDTH-1];
        m = s ? -acc : acc;
        p = 0;
        for (int i = 0; i < ACC_WIDTH; i++) begin
            if (m[i]) p = i;
        end
        norm = m << (ACC_WIDTH - 1 - p);
        mant = norm[ACC_WIDTH-2 -: 10];
        e    = int'(ex) - FRAC_BITS + p;
        if (m == '0)      res = 16'h0000;
        else if (e >= 31) res = {s, 15'h7C00};
        else if (e <= 0)  res = {s, 15'h0000};
        else              res = {s, e[4:0], mant};
        return res;
    endfunction

    assign done_edge = done_in & ~done_q;
    assign nxt_idx   = idx_q + 1'b1;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        data_d  = data_q;
        valid_d = valid_q;
        last_d  = last_q;
        busy_d  = busy_q;
        ovr_d   = ovr_q | (done_edge && (state_q != IDLE));
        capture = 1'b0;
        case (state_q)
            IDLE: begin
                if (done_edge) begin
                    capture = 1'b1;
                    idx_d   = '0;
                    busy_d  = 1'b1;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                data_d  = fp16_convert(snap_acc_q[0], snap_exp_q[0]);
                idx_d   = '0;
                last_d  = (NPE == 1);
                valid_d = 1'b1;
                state_d = SEND;
            end
            SEND: begin
                if (valid_q && res_ready) begin
                    if (last_q) begin
                        valid_d = 1'b0;
                        last_d  = 1'b0;
                        busy_d  = 1'b0;
                        state_d = IDLE;
                    end else begin
                        idx_d  = nxt_idx;
                        data_d = fp16_convert(snap_acc_q[nxt_idx], snap_exp_q[nxt_idx]);
                        last_d = (nxt_idx == IDX_W'(NPE - 1));
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            done_q  <= 1'b0;
            idx_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            busy_q  <= 1'b0;
            ovr_q   <= 1'b0;
            for (int k = 0; k < NPE; k++) begin
                snap_acc_q[k] <= '0;
                snap_exp_q[k] <= '0;
            end
        end else begin
            state_q <= state_d;
            done_q  <= done_in;
            idx_q   <= idx_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            busy_q  <= busy_d;
            ovr_q   <= ovr_d;
            if (capture) begin
                for (int k = 0; k < NPE; k++) begin
                    snap_acc_q[k] <= acc_in[k*ACC_WIDTH +: ACC_WIDTH];
                    snap_exp_q[k] <= exp_in[k*5 +: 5];
                end
            end
        end
    end

    assign res_data  = data_q;
    assign res_idx   = idx_q;
    assign res_valid = valid_q;
    assign res_last  = last_q;
    assign busy      = busy_q;
    assign overrun   = ovr_q;

endmodule
